// File: rtl/tt_um_qsn_inv_if.sv
// Valid/ready block transfer channel used on both sides of the inverse QSN.
// The master drives data and valid; the slave returns ready.
interface tt_um_qsn_inv_if #(
    parameter int unsigned Width = 4
);
    logic [Width-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/tt_um_qsn_inv.sv
// Inverse quasi-cyclic shift network: pops the oldest forward-shift tag and
// re-aligns each returning block, with a registered valid/ready output stage.
module tt_um_qsn_inv #(
    parameter int unsigned LiftingFactor = 4,
    parameter int unsigned ShiftWidth    = 2,
    parameter int unsigned FifoDepth     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  shift_push,
    input  logic [ShiftWidth-1:0] shift_in,
    tt_um_qsn_inv_if.slave        in_if,
    tt_um_qsn_inv_if.master       out_if,
    output logic [ShiftWidth:0]   fifo_level,
    output logic                  overflow,
    output logic [7:0]            block_count
);

    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [ShiftWidth:0] FullLevel = (ShiftWidth + 1)'(FifoDepth);

    logic [ShiftWidth-1:0]    tag_q [FifoDepth];
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [ShiftWidth:0]      level_q, level_d;
    logic                     overflow_q, overflow_d;
    logic [7:0]               count_q, count_d;
    logic [LiftingFactor-1:0] o_q, o_d;
    logic                     valid_q, valid_d;

    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     in_ready;
    logic                     in_xfer;
    logic                     out_xfer;
    logic                     push_req;
    logic                     push_ok;
    logic [ShiftWidth-1:0]    head_tag;
    logic [LiftingFactor-1:0] derot;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FullLevel);
    assign head_tag   = tag_q[rd_ptr_q];

    // Depends only on registered state and out_ready, never on in_valid.
    assign in_ready = ena && !fifo_empty && (!valid_q || out_if.ready);
    assign in_xfer  = in_if.valid && in_ready;
    assign out_xfer = ena && valid_q && out_if.ready;
    assign push_req = ena && shift_push;
    assign push_ok  = push_req && (!fifo_full || in_xfer);

    // O[j] = I[(j - s) mod LiftingFactor], with the index wrapping in ShiftWidth bits.
    always_comb begin
        logic [ShiftWidth-1:0] src_idx;
        derot   = '0;
        src_idx = '0;
        for (int j = 0; j < LiftingFactor; j++) begin
            src_idx  = ShiftWidth'(j) - head_tag;
            derot[j] = in_if.data[src_idx];
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        o_d        = o_q;
        valid_d    = valid_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (in_xfer) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, in_xfer})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end

        if (out_xfer) begin
            count_d = count_q + 8'd1;
        end

        if (in_xfer) begin
            o_d     = derot;
            valid_d = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FifoDepth; i++) begin
                tag_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            o_q        <= '0;
            valid_q    <= 1'b0;
        end else begin
            // On a full FIFO with a simultaneous pop, wr_ptr equals rd_ptr; the
            // head has already been read combinationally, so overwriting it is safe.
            if (push_ok) begin
                tag_q[wr_ptr_q] <= shift_in;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            o_q        <= o_d;
            valid_q    <= valid_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.data  = o_q;
    assign out_if.valid = valid_q;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign block_count  = count_q;

endmodule

// File: tb/tb_tt_um_qsn_inv.sv
// Randomized and directed bench for tt_um_qsn_inv against a queue-based reference model.
module tb_tt_um_qsn_inv;

    localparam int L     = 4;
    localparam int SW    = 2;
    localparam int Depth = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          shift_push = 1'b0;
    logic [SW-1:0] shift_in = '0;
    logic [SW:0]   fifo_level;
    logic          overflow;
    logic [7:0]    block_count;

    tt_um_qsn_inv_if #(.Width(L)) in_if ();
    tt_um_qsn_inv_if #(.Width(L)) out_if ();

    tt_um_qsn_inv #(
        .LiftingFactor(L),
        .ShiftWidth   (SW),
        .FifoDepth    (Depth)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .shift_push (shift_push),
        .shift_in   (shift_in),
        .in_if      (in_if),
        .out_if     (out_if),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .block_count(block_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         tag_q[$];
    logic       m_valid;
    logic [3:0] m_o;
    logic       m_ovf;
    int         m_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output bit j takes input bit (j - s) mod L.
    function automatic logic [3:0] derotate(input logic [3:0] d, input int s);
        logic [3:0] r;
        for (int j = 0; j < L; j++) r[j] = d[(j - s + L) % L];
        return r;
    endfunction

    // Pre-rotation that the datapath would have applied, so derotate(fwd(d,s),s) == d.
    function automatic logic [3:0] forward(input logic [3:0] d, input int s);
        logic [3:0] r;
        for (int k = 0; k < L; k++) r[k] = d[(k + s) % L];
        return r;
    endfunction

    task automatic model_clear();
        tag_q.delete();
        m_valid = 1'b0;
        m_o     = '0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock cycle: drive, check in_ready, advance model, check registered outputs.
    task automatic step(input logic e, input logic p, input int s, input logic v,
                        input logic [3:0] d, input logic r);
        logic rdy, pop, otx;
        int   sz;
        ena          = e;
        shift_push   = p;
        shift_in     = SW'(s);
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = r;
        #1;
        rdy = e && (tag_q.size() != 0) && (!m_valid || r);
        check_eq("in_ready", {31'd0, in_if.ready}, {31'd0, rdy});
        pop = v && rdy;
        otx = m_valid && r && e;
        sz  = tag_q.size();
        if (pop) begin
            m_o     = derotate(d, tag_q.pop_front());
            m_valid = 1'b1;
        end else if (otx) begin
            m_valid = 1'b0;
        end
        if (otx) m_cnt = (m_cnt + 1) % 256;
        if (e && p) begin
            if (sz < Depth || pop) tag_q.push_back(s % L);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", {31'd0, out_if.valid}, {31'd0, m_valid});
        check_eq("O", {28'd0, out_if.data}, {28'd0, m_o});
        check_eq("fifo_level", {29'd0, fifo_level}, 32'(tag_q.size()));
        check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check_eq("block_count", {24'd0, block_count}, 32'(m_cnt));
    endtask

    // Asynchronous reset asserted mid-cycle; state must clear with no clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
        check_eq("rst_O", {28'd0, out_if.data}, 32'd0);
        check_eq("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        check_eq("rst_block_count", {24'd0, block_count}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_if.ready}, 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Basic inverse: tag 1, block 0011 -> 0110
        step(1, 1, 1, 0, 4'h0, 1);
        step(1, 0, 0, 1, 4'b0011, 1);
        check_eq("basic_O", {28'd0, out_if.data}, 32'b0110);
        step(1, 0, 0, 0, 4'h0, 1);
        check_eq("basic_count", {24'd0, block_count}, 32'd1);

        // Round trip over all data and shifts
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < L; s++) begin
                step(1, 1, s, 0, 4'h0, 1);
                step(1, 0, 0, 1, forward(4'(d), s), 1);
                check_eq("roundtrip", {28'd0, out_if.data}, 32'(d));
            end
        end
        step(1, 0, 0, 0, 4'h0, 1);

        // Ordering and backpressure
        do_reset();
        step(1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 2, 0, 4'h0, 0);
        step(1, 1, 3, 0, 4'h0, 0);
        step(1, 0, 0, 1, 4'b1001, 0);
        step(1, 0, 0, 1, 4'b0101, 0);
        step(1, 0, 0, 1, 4'b0101, 0);
        check_eq("stall_O", {28'd0, out_if.data}, {28'd0, derotate(4'b1001, 1)});
        step(1, 0, 0, 1, 4'b0101, 1);
        check_eq("order2_O", {28'd0, out_if.data}, {28'd0, derotate(4'b0101, 2)});
        step(1, 0, 0, 1, 4'b0111, 1);
        check_eq("order3_O", {28'd0, out_if.data}, {28'd0, derotate(4'b0111, 3)});
        step(1, 0, 0, 0, 4'h0, 1);
        check_eq("order_level", {29'd0, fifo_level}, 32'd0);

        // Full FIFO, dropped fifth tag, then push+pop while full
        do_reset();
        step(1, 1, 1, 0, 4'h0, 1);
        step(1, 1, 2, 0, 4'h0, 1);
        step(1, 1, 3, 0, 4'h0, 1);
        step(1, 1, 0, 0, 4'h0, 1);
        step(1, 1, 2, 0, 4'h0, 1);
        check_eq("full_level", {29'd0, fifo_level}, 32'd4);
        check_eq("full_overflow", {31'd0, overflow}, 32'd1);
        step(1, 1, 3, 1, 4'b0001, 1);
        check_eq("pushpop_level", {29'd0, fifo_level}, 32'd4);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 4'(i + 3), 1);

        // Empty stall, then a tag releases the block
        step(1, 0, 0, 1, 4'b1100, 1);
        step(1, 0, 0, 1, 4'b1100, 1);
        step(1, 1, 2, 1, 4'b1100, 1);
        step(1, 0, 0, 1, 4'b1100, 1);
        check_eq("release_O", {28'd0, out_if.data}, {28'd0, derotate(4'b1100, 2)});

        // Enable low freezes everything
        step(1, 1, 1, 0, 4'h0, 0);
        step(0, 1, 3, 1, 4'b1010, 1);
        step(0, 1, 3, 1, 4'b1010, 1);
        step(1, 0, 0, 1, 4'b1010, 1);
        step(1, 0, 0, 0, 4'h0, 1);

        // Mid-run reset with out_valid=1 and fifo_level=3
        step(1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 2, 0, 4'h0, 0);
        step(1, 1, 3, 0, 4'h0, 0);
        step(1, 1, 0, 0, 4'h0, 0);
        step(1, 0, 0, 1, 4'b0110, 0);
        check_eq("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        do_reset();

        // 256 back-to-back transfers wrap block_count
        step(1, 1, 1, 0, 4'h0, 1);
        for (int i = 0; i < 256; i++) step(1, 1, $urandom_range(0, 3), 1, 4'($urandom), 1);
        step(1, 0, 0, 0, 4'h0, 1);
        check_eq("count_wrap", {24'd0, block_count}, 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
